// File: rtl/rr_mux_sel_arbiter.sv
// Purpose: 4-channel round-robin arbiter driving a 4:1 mux select, with a registered valid/ready output stage.
// Latency: request sampled at edge k gives out_valid/sel/gnt/out_data right after edge k (1 cycle).
// Backpressure: while out_ready=0 the grant, select and captured data are held; transfers re-arbitrate with no bubble.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   req[3:0]          per-channel request (a=0, b=1, c=2, d=3)
//   a, b, c, d        channel data, DW bits each
//   out_ready         downstream accepts out_data this cycle
//   sel[1:0]          current grant index (mux select)
//   gnt[3:0]          one-hot grant, zero when idle
//   out_valid         out_data holds a granted sample
//   out_data[DW-1:0]  captured data of the granted channel
//   ack[3:0]          one-cycle pulse when a channel's transfer completes
//   grant_cnt         per-channel saturating transfer counters, present only with RR_ARB_STATS_EN
//
// Optional feature macro: RR_ARB_STATS_EN
module rr_mux_sel_arbiter #(
  parameter int DW    = 1,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req,
  input  logic [DW-1:0]        a,
  input  logic [DW-1:0]        b,
  input  logic [DW-1:0]        c,
  input  logic [DW-1:0]        d,
  input  logic                 out_ready,
  output logic [1:0]           sel,
  output logic [3:0]           gnt,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  output logic [3:0]           ack
`ifdef RR_ARB_STATS_EN
  ,
  output logic [4*CNT_W-1:0]   grant_cnt
`endif
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        state, state_nx;
  logic [1:0]    ptr, ptr_nx;
  logic [1:0]    sel_nx;
  logic [3:0]    gnt_nx;
  logic          vld_nx;
  logic [DW-1:0] data_nx;
  logic [3:0]    ack_nx;

  logic [1:0]    scan_base;
  logic [1:0]    idx;
  logic [1:0]    win;
  logic          win_vld;
  logic [DW-1:0] win_data;
  logic          load;

  // On a transfer the pointer moves past the served channel in the same
  // cycle, so the just-served channel is scanned last.
  always_comb begin
    scan_base = ptr;
    if (state == HOLD && out_ready) begin
      scan_base = sel + 2'd1;
    end
    win_vld = 1'b0;
    win     = scan_base;
    idx     = scan_base;
    // Walk from the farthest offset to the nearest so the nearest set bit wins.
    for (int k = 3; k >= 0; k--) begin
      idx = scan_base + 2'(k);
      if (req[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
  end

  always_comb begin
    win_data = a;
    case (win)
      2'd0:    win_data = a;
      2'd1:    win_data = b;
      2'd2:    win_data = c;
      default: win_data = d;
    endcase
  end

  // Next-state and output-register values.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    sel_nx   = sel;
    gnt_nx   = gnt;
    vld_nx   = out_valid;
    data_nx  = out_data;
    ack_nx   = 4'b0000;
    load     = 1'b0;

    case (state)
      IDLE: begin
        if (win_vld) begin
          load = 1'b1;
        end
      end
      HOLD: begin
        // Without out_ready everything is frozen; req and data are ignored.
        if (out_ready) begin
          ack_nx = gnt;
          ptr_nx = sel + 2'd1;
          if (win_vld) begin
            load = 1'b1;
          end else begin
            state_nx = IDLE;
            vld_nx   = 1'b0;
            gnt_nx   = 4'b0000;
          end
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    if (load) begin
      state_nx = HOLD;
      sel_nx   = win;
      gnt_nx   = 4'b0001 << win;
      vld_nx   = 1'b1;
      data_nx  = win_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      sel       <= 2'd0;
      gnt       <= 4'b0000;
      out_valid <= 1'b0;
      out_data  <= '0;
      ack       <= 4'b0000;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      sel       <= sel_nx;
      gnt       <= gnt_nx;
      out_valid <= vld_nx;
      out_data  <= data_nx;
      ack       <= ack_nx;
    end
  end

`ifdef RR_ARB_STATS_EN
  // Counters advance on the transfer edge, i.e. together with the ack pulse.
  for (genvar i = 0; i < 4; i++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (rst) begin
        grant_cnt[i*CNT_W +: CNT_W] <= '0;
      end else if (ack_nx[i] && (grant_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
        grant_cnt[i*CNT_W +: CNT_W] <= grant_cnt[i*CNT_W +: CNT_W] + 1'b1;
      end
    end
  end
`else
  // CNT_W only sizes the stats counters; nothing to build here.
  if (CNT_W < 1) begin : g_no_stats
  end
`endif

endmodule

// File: tb/tb_rr_mux_sel_arbiter.sv
module tb_rr_mux_sel_arbiter;
  localparam int DW    = 8;
  localparam int CNT_W = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic [DW-1:0] a, b, c, d;
  logic          out_ready;
  logic [1:0]    sel;
  logic [3:0]    gnt;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [3:0]    ack;
`ifdef RR_ARB_STATS_EN
  logic [4*CNT_W-1:0] grant_cnt;
`endif

  rr_mux_sel_arbiter #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_ready (out_ready),
    .sel       (sel),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .ack       (ack)
`ifdef RR_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Abstract view: either idle, or holding one granted channel and its
  // captured sample. The rotating priority is just an integer start index.
  bit            m_busy;
  int            m_sel;
  int            m_ptr;
  logic [DW-1:0] m_data;
  logic [3:0]    m_ack;
  bit            m_just_reset;

  function automatic logic [DW-1:0] chan(input int i);
    case (i)
      0:       return a;
      1:       return b;
      2:       return c;
      default: return d;
    endcase
  endfunction

  task automatic model_edge();
    bit may_grant;
    m_ack        = 4'b0000;
    m_just_reset = 1'b0;
    if (rst) begin
      m_busy       = 1'b0;
      m_sel        = 0;
      m_ptr        = 0;
      m_data       = '0;
      m_just_reset = 1'b1;
    end else begin
      may_grant = !m_busy || (out_ready == 1'b1);
      if (m_busy && out_ready) begin
        m_ack[m_sel] = 1'b1;
        m_ptr        = (m_sel + 1) % 4;
        m_busy       = 1'b0;
      end
      if (may_grant) begin
        for (int k = 0; k < 4; k++) begin
          if (!m_busy && req[(m_ptr + k) % 4]) begin
            m_busy = 1'b1;
            m_sel  = (m_ptr + k) % 4;
            m_data = chan(m_sel);
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_sel", 32'(sel), 32'(m_sel));
    chk("model_gnt", 32'(gnt), m_busy ? (32'd1 << m_sel) : 32'd0);
    chk("model_valid", 32'(out_valid), 32'(m_busy));
    chk("model_ack", 32'(ack), 32'(m_ack));
    if (m_busy || m_just_reset) chk("model_data", 32'(out_data), 32'(m_data));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic [7:0] c;
    logic [1:0] e_sel;
    logic [3:0] e_gnt;
    logic       e_vld;
    logic [7:0] e_data;
    logic [3:0] e_ack;
  } vec_t;

  vec_t tbl[25];

  initial begin
    // rst  req    rdy   c      sel    gnt     vld   data   ack
    tbl[0]  = '{1'b1, 4'hF, 1'b0, 8'h33, 2'd0, 4'h0, 1'b0, 8'h00, 4'h0}; // reset, req all
    tbl[1]  = '{1'b1, 4'hF, 1'b0, 8'h33, 2'd0, 4'h0, 1'b0, 8'h00, 4'h0};
    tbl[2]  = '{1'b0, 4'hF, 1'b0, 8'h33, 2'd0, 4'h1, 1'b1, 8'h11, 4'h0}; // first grant ch0
    tbl[3]  = '{1'b0, 4'hF, 1'b1, 8'h33, 2'd1, 4'h2, 1'b1, 8'h22, 4'h1}; // fairness run
    tbl[4]  = '{1'b0, 4'hE, 1'b1, 8'h33, 2'd2, 4'h4, 1'b1, 8'h33, 4'h2};
    tbl[5]  = '{1'b0, 4'hD, 1'b1, 8'h33, 2'd3, 4'h8, 1'b1, 8'h44, 4'h4};
    tbl[6]  = '{1'b0, 4'hB, 1'b1, 8'h33, 2'd0, 4'h1, 1'b1, 8'h11, 4'h8};
    tbl[7]  = '{1'b0, 4'h7, 1'b1, 8'h33, 2'd1, 4'h2, 1'b1, 8'h22, 4'h1};
    tbl[8]  = '{1'b0, 4'h0, 1'b1, 8'h33, 2'd1, 4'h0, 1'b0, 8'h00, 4'h2}; // to idle, sel kept
    tbl[9]  = '{1'b0, 4'h4, 1'b0, 8'h5A, 2'd2, 4'h4, 1'b1, 8'h5A, 4'h0}; // backpressure
    tbl[10] = '{1'b0, 4'h4, 1'b0, 8'hFF, 2'd2, 4'h4, 1'b1, 8'h5A, 4'h0};
    tbl[11] = '{1'b0, 4'h4, 1'b0, 8'hFF, 2'd2, 4'h4, 1'b1, 8'h5A, 4'h0};
    tbl[12] = '{1'b0, 4'h4, 1'b0, 8'hFF, 2'd2, 4'h4, 1'b1, 8'h5A, 4'h0};
    tbl[13] = '{1'b0, 4'h0, 1'b1, 8'hFF, 2'd2, 4'h0, 1'b0, 8'h00, 4'h4};
    tbl[14] = '{1'b0, 4'h0, 1'b0, 8'hFF, 2'd2, 4'h0, 1'b0, 8'h00, 4'h0};
    tbl[15] = '{1'b0, 4'h9, 1'b0, 8'h33, 2'd3, 4'h8, 1'b1, 8'h44, 4'h0}; // ptr=3 wrap
    tbl[16] = '{1'b0, 4'h9, 1'b1, 8'h33, 2'd0, 4'h1, 1'b1, 8'h11, 4'h8};
    tbl[17] = '{1'b0, 4'h0, 1'b1, 8'h33, 2'd0, 4'h0, 1'b0, 8'h00, 4'h1};
    tbl[18] = '{1'b0, 4'h2, 1'b0, 8'h33, 2'd1, 4'h2, 1'b1, 8'h22, 4'h0}; // reset mid-HOLD
    tbl[19] = '{1'b1, 4'h2, 1'b0, 8'h33, 2'd0, 4'h0, 1'b0, 8'h00, 4'h0};
    tbl[20] = '{1'b0, 4'hF, 1'b0, 8'h33, 2'd0, 4'h1, 1'b1, 8'h11, 4'h0};
    tbl[21] = '{1'b0, 4'h0, 1'b1, 8'h33, 2'd0, 4'h0, 1'b0, 8'h00, 4'h1};
    tbl[22] = '{1'b0, 4'h2, 1'b0, 8'h33, 2'd1, 4'h2, 1'b1, 8'h22, 4'h0};
    tbl[23] = '{1'b1, 4'h0, 1'b1, 8'h33, 2'd0, 4'h0, 1'b0, 8'h00, 4'h0}; // reset beats transfer
    tbl[24] = '{1'b0, 4'hF, 1'b0, 8'h33, 2'd0, 4'h1, 1'b1, 8'h11, 4'h0};

    m_busy = 1'b0; m_sel = 0; m_ptr = 0; m_data = '0; m_ack = '0; m_just_reset = 1'b0;
    rst = 1'b1; req = 4'h0; out_ready = 1'b0;
    a = 8'h11; b = 8'h22; c = 8'h33; d = 8'h44;
    #2;

    for (int i = 0; i < 25; i++) begin
      rst       = tbl[i].rst;
      req       = tbl[i].req;
      out_ready = tbl[i].rdy;
      c         = tbl[i].c;
      tick();
      chk($sformatf("tbl%0d_sel", i), 32'(sel), 32'(tbl[i].e_sel));
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].e_gnt));
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_ack", i), 32'(ack), 32'(tbl[i].e_ack));
      if (tbl[i].e_vld || tbl[i].rst)
        chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].e_data));
    end

    // ---------------- randomized run against the model ----------------
    for (int n = 0; n < 1500; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      req       = 4'($urandom);
      if ($urandom_range(0, 3) == 0) req = 4'h0;
      out_ready = ($urandom_range(0, 3) != 0);
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
      tick();
    end

`ifdef RR_ARB_STATS_EN
    // ---------------- saturating counters, CNT_W=2 ----------------
    rst = 1'b1; req = 4'h0; out_ready = 1'b0;
    tick();
    chk("stats_reset", 32'(grant_cnt), 32'd0);
    rst = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      req = 4'b0100; out_ready = 1'b0; tick();
      req = 4'b0000; out_ready = 1'b1; tick();
      req = 4'b0000; out_ready = 1'b0; tick();
      chk($sformatf("stats_ch2_n%0d", n), 32'(grant_cnt[2*CNT_W +: CNT_W]), (n < 3) ? 32'(n) : 32'd3);
      chk($sformatf("stats_others_n%0d", n), 32'(grant_cnt & ~(8'h3 << (2*CNT_W))), 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_mux_sel_arbiter.md
Name: rr_mux_sel_arbiter

Overview:
- 4-channel round-robin arbiter with a registered output stage; sits directly upstream of the 4:1 mux datapath.
- Drives the mux select, and also captures the selected channel's data into a valid/ready output register.
- Gives fair access to a shared 4:1 path; the downstream consumer can apply backpressure.

Parameters:
DW, 1, data width of each channel input and of out_data
CNT_W, 8, width of each per-channel grant counter (used only with RR_ARB_STATS_EN)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
req  input  4  request per channel; bit i = channel i (a=0, b=1, c=2, d=3)
a  input  DW  channel 0 data
b  input  DW  channel 1 data
c  input  DW  channel 2 data
d  input  DW  channel 3 data
out_ready  input  1  downstream accepts out_data this cycle
sel  output  2  index of current grant; drives the downstream mux select
gnt  output  4  one-hot grant; all-zero when idle
out_valid  output  1  out_data holds a granted sample
out_data  output  DW  registered data of the granted channel
ack  output  4  one-cycle pulse on bit i when channel i's transfer completes
grant_cnt  output  4*CNT_W  per-channel completed-transfer counts, channel i at [i*CNT_W +: CNT_W] (only with RR_ARB_STATS_EN)

Behaviour:
- One clock domain. Reset is synchronous and active-high: clk rising edge, rst=1.
- Reset values: sel=0, gnt=0, out_valid=0, out_data=0, ack=0, grant_cnt=0. Priority pointer ptr=0, state=IDLE.
- Reset mid-HOLD: at the reset edge, state returns to IDLE, out_valid=0, no ack is issued, and ptr=0.
- The FSM has two states, IDLE and HOLD.
- Arbitration, evaluated on req at the edge: scan channels ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first set bit wins; call it w.
- Grant load (on arbitration with any req set):
  - sel=w, gnt=1<<w, out_valid=1.
  - out_data = data of channel w sampled at that edge.
  - State=HOLD.
  - Latency: req seen at edge k gives out_valid=1 immediately after edge k, i.e. one cycle.
- IDLE:
  - req=0 keeps IDLE with gnt=0; sel keeps its last value.
  - Any req set: perform a grant load.
- HOLD with out_ready=0:
  - sel, gnt, out_data and out_valid are all held.
  - Changes on a, b, c, d and req are ignored; a grant is never retracted, even if req[w] drops.
- HOLD with out_ready=1 (transfer at this edge):
  - ack[w]=1 for exactly one cycle after the edge.
  - ptr=(w+1) mod 4.
  - Back-to-back: arbitration runs at the same edge using the updated ptr. Any req set performs a grant load with no bubble cycle; otherwise go to IDLE with out_valid=0 and gnt=0.
  - The just-served channel has lowest priority in that same-edge arbitration. It is re-granted only if it is the sole requester.
- Requester contract: deassert req in the cycle following ack, or it is treated as a new request.
- ack is 0 in every cycle except the single pulse after a transfer. gnt always equals 1<<sel while out_valid=1.

Optional Feature:
- Macro: RR_ARB_STATS_EN.
- Defined:
  - grant_cnt port present.
  - Counter i increments by 1 on each completed transfer of channel i (ack[i] rising).
  - Each counter saturates at 2^CNT_W-1 and does not wrap.
  - All counters clear on rst.
- Not defined: grant_cnt port and counters absent; all other behaviour identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req=4'b1111 -> out_valid=0, gnt=0, sel=0, ack=0 throughout. First grant after release is channel 0.
- Fairness: req=4'b1111 held, out_ready=1, acked channel's req dropped for one cycle then reasserted -> grants 0,1,2,3,0 on consecutive cycles with no bubbles. ack pulses 0001,0010,0100,1000,0001.
- Backpressure: DW=8, req=4'b0100, c=8'h5A; out_ready=0 for 3 cycles while c changes to 8'hFF -> sel=2, gnt=0100, out_data=8'h5A stable. On out_ready=1: one ack=0100 pulse, then IDLE.
- Pointer wrap: ptr=3 (after a channel 2 transfer), req=4'b1001 -> channel 3 granted. After its transfer, with req=4'b1001 still held, channel 0 is granted.
- Reset mid-HOLD: grant on channel 1 with out_ready=0, assert rst for 1 cycle -> out_valid=0, no ack. Next grant with req=4'b1111 is channel 0.
- Stats (RR_ARB_STATS_EN, CNT_W=2): 5 completed transfers on channel 2 -> grant_cnt for channel 2 reads 1,2,3,3,3 and the other channels stay 0.
